// File: rtl/hs_spi_pkg.sv
// Shared definitions for the high-speed multi-lane SPI master and slave:
// frame state encoding and the reset values of the pin synchronizers.
package hs_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    // Synchronizer reset values match the idle level of each pin
    localparam logic SCK_SYNC_RST  = 1'b0;
    localparam logic CSN_SYNC_RST  = 1'b1;
    localparam logic MOSI_SYNC_RST = 1'b0;

endpackage

// File: rtl/hs_spi_sync_slave_m_if.sv
// Bus-side signals of the oversampling SPI slave: the local transmit/receive
// handshake plus the SPI pins themselves.
interface hs_spi_sync_slave_m_if #(
    parameter int DW    = 32,
    parameter int SPI_W = 4
);
    logic             load;
    logic             empty;
    logic             busy;
    logic [DW-1:0]    data_in;
    logic [DW-1:0]    data_out;
    logic             valid;
    logic             err;
    logic             SCK;
    logic             CSn;
    logic [SPI_W-1:0] MOSI;
    logic [SPI_W-1:0] MISO;

    modport slave (
        input  load, data_in, SCK, CSn, MOSI,
        output empty, busy, data_out, valid, err, MISO
    );

    modport master (
        output load, data_in, SCK, CSn, MOSI,
        input  empty, busy, data_out, valid, err, MISO
    );
endinterface

// File: rtl/hs_spi_edge_det_m.sv
// Synchronizes one asynchronous pin into clk and produces registered
// single-cycle rise/fall strobes. Strobes are held off until the edge
// register holds a genuinely sampled level, so a pin that already sits away
// from its reset value when rst is released does not create a phantom edge.
module hs_spi_edge_det_m #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;
    logic                   w_primed;

    assign w_level  = r_sync[SYNC_STAGES-1];
    assign w_primed = r_fill[SYNC_STAGES];

    // Synchronizer chain, edge-detect register and gated strobe generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_fill <= '0;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_prev <= w_level;
            r_rise <= w_primed & w_level & ~r_prev;
            r_fall <= w_primed & ~w_level & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/hs_spi_sync_slave_m.sv
// Oversampling multi-lane SPI slave. SCK, CSn and MOSI are sampled on the
// local clock; one word is received and one word returned per CSn assertion.
module hs_spi_sync_slave_m
    import hs_spi_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SPI_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst,
    hs_spi_sync_slave_m_if.slave io_bus
);

    localparam int SLICE_COUNT = DW / SPI_W;
    localparam int CW          = (SLICE_COUNT > 1) ? $clog2(SLICE_COUNT) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(SLICE_COUNT - 1);

    spi_state_e       r_state, w_stateNext;
    logic [CW-1:0]    r_cnt, w_cntNext;
    logic             r_empty, w_emptyNext;
    logic [DW-1:0]    r_databuf, w_bufNext;
    logic [DW-1:0]    r_txSr, w_txNext;
    logic [DW-1:0]    r_rxSr, w_rxNext;
    logic [DW-1:0]    r_dataOut, w_dataOutNext;
    logic             r_valid, w_validNext;
    logic             r_err, w_errNext;
    logic [SPI_W-1:0] r_miso, w_misoNext;
    logic             r_busy;
    logic [SPI_W-1:0] r_mosiSync [SYNC_STAGES];
    logic [SPI_W-1:0] w_mosi;
    logic [DW-1:0]    w_rxShift, w_txShift;
    logic             w_sckFall, w_sckRiseUnused, w_csFall, w_csRise;
    logic             w_lastSample;

    hs_spi_edge_det_m #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCK_SYNC_RST)) u_sckDet (
        .clk(clk), .rst(rst), .i_pin(io_bus.SCK),
        .o_rise(w_sckRiseUnused), .o_fall(w_sckFall)
    );

    hs_spi_edge_det_m #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CSN_SYNC_RST)) u_csDet (
        .clk(clk), .rst(rst), .i_pin(io_bus.CSn),
        .o_rise(w_csRise), .o_fall(w_csFall)
    );

    // MOSI lanes only need plain synchronization; they are stable around SCK fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_mosiSync[i] <= {SPI_W{MOSI_SYNC_RST}};
        end else begin
            r_mosiSync[0] <= io_bus.MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) r_mosiSync[i] <= r_mosiSync[i-1];
        end
    end

    assign w_mosi       = r_mosiSync[SYNC_STAGES-1];
    assign w_rxShift    = (r_rxSr << SPI_W) | DW'(w_mosi);
    assign w_txShift    = r_txSr << SPI_W;
    assign w_lastSample = w_sckFall && (r_cnt == LAST_SLICE);

    // Next-state and datapath decisions; a same-cycle SCK sample is taken before CSn rise
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_emptyNext   = r_empty;
        w_bufNext     = r_databuf;
        w_txNext      = r_txSr;
        w_rxNext      = r_rxSr;
        w_dataOutNext = r_dataOut;
        w_validNext   = 1'b0;
        w_errNext     = 1'b0;
        w_misoNext    = r_miso;

        case (r_state)
            ST_IDLE: begin
                if (w_csFall) begin
                    w_txNext    = r_empty ? '0 : r_databuf;
                    w_emptyNext = 1'b1;
                    w_cntNext   = '0;
                    w_misoNext  = w_txNext[DW-1 -: SPI_W];
                    w_stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_sckFall) begin
                    w_rxNext   = w_rxShift;
                    w_txNext   = w_txShift;
                    w_misoNext = w_txShift[DW-1 -: SPI_W];
                    if (w_lastSample) begin
                        w_dataOutNext = w_rxShift;
                        w_validNext   = 1'b1;
                        w_cntNext     = '0;
                        w_stateNext   = ST_DONE;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                if (w_csRise) begin
                    w_errNext   = !w_lastSample;
                    w_misoNext  = '0;
                    w_stateNext = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (w_csRise) begin
                    w_misoNext  = '0;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        if (io_bus.load && r_empty) begin
            w_bufNext   = io_bus.data_in;
            w_emptyNext = 1'b0;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    // Datapath, buffer and registered output updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_empty   <= 1'b1;
            r_databuf <= '0;
            r_txSr    <= '0;
            r_rxSr    <= '0;
            r_dataOut <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_miso    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cntNext;
            r_empty   <= w_emptyNext;
            r_databuf <= w_bufNext;
            r_txSr    <= w_txNext;
            r_rxSr    <= w_rxNext;
            r_dataOut <= w_dataOutNext;
            r_valid   <= w_validNext;
            r_err     <= w_errNext;
            r_miso    <= w_misoNext;
            r_busy    <= (w_stateNext != ST_IDLE);
        end
    end

    assign io_bus.empty    = r_empty;
    assign io_bus.busy     = r_busy;
    assign io_bus.data_out = r_dataOut;
    assign io_bus.valid    = r_valid;
    assign io_bus.err      = r_err;
    assign io_bus.MISO     = r_miso;

endmodule
